hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the enable, clear and flush inputs of the F/D/E/M pipeline registers and the forwarding mux selects.
- Resolves load-use and branch-compare hazards combinationally.
- Runs a small FSM that freezes the pipeline while a multi-cycle data memory is not ready. A timeout error state and saturating performance counters are included.

---
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: forwarding selects,
// load-use/branch stalls, memory-wait freeze FSM and perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitNext;
    logic              lwStall;
    logic              branchStall;
    logic              hz;
    logic              memFreeze;

    // $0 is hardwired zero, so it never creates a dependency
    function automatic logic match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    assign lwStall = MemtoRegE && (match(RtE, RsD) || match(RtE, RtD));

    assign branchStall = BranchD &&
        ((RegWriteE && (match(WriteRegE, RsD) || match(WriteRegE, RtD))) ||
         (MemtoRegM && (match(WriteRegM, RsD) || match(WriteRegM, RtD))));

    assign hz = lwStall || branchStall;

    assign memFreeze = (state == RUN && MemReqM && !MemReadyM) ||
                       (state == MEM_WAIT && !MemReadyM);

    assign waitNext = waitCnt + WAIT_W'(1);

    // Forwarding selects; the younger M result beats W
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        if (!reset) begin
            if (RegWriteM && match(WriteRegM, RsE))
                ForwardAE = 2'b10;
            else if (RegWriteW && match(WriteRegW, RsE))
                ForwardAE = 2'b01;
            if (RegWriteM && match(WriteRegM, RtE))
                ForwardBE = 2'b10;
            else if (RegWriteW && match(WriteRegW, RtE))
                ForwardBE = 2'b01;
            ForwardAD = RegWriteM && match(WriteRegM, RsD);
            ForwardBD = RegWriteM && match(WriteRegM, RtD);
        end
    end

    // Stall/flush decode: reset, then error/memory freeze, then hazards
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        priority case (1'b1)
            reset: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
            (state == ERROR), memFreeze: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end
            default: begin
                StallF = hz;
                StallD = hz;
                FlushE = hz;
                FlushD = PCSrcD && !hz;
            end
        endcase
    end

    // Memory-wait FSM with timeout into a sticky error state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitNext >= WAIT_W'(MEM_TIMEOUT)) begin
                        state   <= ERROR;
                        waitCnt <= WAIT_W'(MEM_TIMEOUT);
                        MemErr  <= 1'b1;
                    end else begin
                        waitCnt <= waitNext;
                    end
                end
                ERROR: state <= ERROR;
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF && StallCycles != '1)
                StallCycles <= StallCycles + CNT_W'(1);
            if ((FlushD || FlushE) && FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, directed multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    typedef struct packed {
        logic [4:0] RsD, RtD, RsE, RtE;
        logic [4:0] WriteRegE, WriteRegM, WriteRegW;
        logic RegWriteE, RegWriteM, RegWriteW;
        logic MemtoRegE, MemtoRegM, BranchD, PCSrcD;
        logic MemReqM, MemReadyM;
    } in_t;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,AE,BE,AD,BD}
    typedef logic [11:0] comb_t;

    typedef struct packed {
        in_t   in;
        comb_t exp;
    } vec_t;

    localparam comb_t C_NONE = 12'b000000_00_00_00;
    localparam comb_t C_HZ   = 12'b110001_00_00_00;
    localparam comb_t C_FRZ  = 12'b111100_00_00_00;
    localparam comb_t C_RST  = 12'b000011_00_00_00;
    localparam comb_t C_FD   = 12'b000010_00_00_00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, PCSrcD, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, MemErr;
    logic [CW-1:0] StallCycles, FlushCount;

    int nVec = 0;
    int nBad = 0;

    bit mWait, mErr;
    int mCnt, mStall, mFlush;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .MemErr(MemErr), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    task automatic drive(input in_t v);
        RsD = v.RsD; RtD = v.RtD; RsE = v.RsE; RtE = v.RtE;
        WriteRegE = v.WriteRegE; WriteRegM = v.WriteRegM;
        WriteRegW = v.WriteRegW;
        RegWriteE = v.RegWriteE; RegWriteM = v.RegWriteM;
        RegWriteW = v.RegWriteW;
        MemtoRegE = v.MemtoRegE; MemtoRegM = v.MemtoRegM;
        BranchD = v.BranchD; PCSrcD = v.PCSrcD;
        MemReqM = v.MemReqM; MemReadyM = v.MemReadyM;
    endtask

    task automatic apply(input in_t v);
        drive(v);
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        drive('0);
        advance();
        reset = 1'b0;
    endtask

    function automatic comb_t gotComb();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE,
                ForwardAE, ForwardBE, ForwardAD, ForwardBD};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [1:0] fwdSrc(input in_t v, input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (v.RegWriteM && v.WriteRegM == r) return 2'b10;
        if (v.RegWriteW && v.WriteRegW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit readsD(input in_t v, input logic [4:0] d);
        return d != 0 && (d == v.RsD || d == v.RtD);
    endfunction

    function automatic comb_t model(input in_t v, input bit rst,
                                    input bit inWait, input bit err);
        bit lw, br, hz, frz, fd;
        logic [1:0] ad, bd;
        if (rst) return C_RST;
        lw  = v.MemtoRegE && readsD(v, v.RtE);
        br  = v.BranchD && ((v.RegWriteE && readsD(v, v.WriteRegE)) ||
                            (v.MemtoRegM && readsD(v, v.WriteRegM)));
        hz  = lw || br;
        frz = err || (!v.MemReadyM && (inWait || v.MemReqM));
        ad  = fwdSrc(v, v.RsD);
        bd  = fwdSrc(v, v.RtD);
        fd  = v.PCSrcD && !hz;
        if (frz)
            return {4'b1111, 2'b00, fwdSrc(v, v.RsE), fwdSrc(v, v.RtE),
                    ad[1], bd[1]};
        return {hz, hz, 2'b00, fd, hz, fwdSrc(v, v.RsE), fwdSrc(v, v.RtE),
                ad[1], bd[1]};
    endfunction

    vec_t tbl[14];

    initial begin
        in_t v, z, lwv, brv, mem, r;
        comb_t e;
        bit rst;

        z = '0;
        v = z; tbl[0] = '{v, C_NONE};
        v = z; v.RegWriteM = 1; v.WriteRegM = 8; v.RsE = 8;
        v.RegWriteW = 1; v.WriteRegW = 8;
        tbl[1] = '{v, 12'b000000_10_00_00};
        v.WriteRegM = 9; tbl[2] = '{v, 12'b000000_01_00_00};
        v = z; v.RegWriteE = 1; v.RegWriteM = 1; v.RegWriteW = 1;
        tbl[3] = '{v, C_NONE};
        v = z; v.RegWriteM = 1; v.WriteRegM = 8; v.RtE = 8;
        tbl[4] = '{v, 12'b000000_00_10_00};
        v = z; v.RegWriteM = 1; v.WriteRegM = 4; v.RsD = 4; v.RtD = 4;
        tbl[5] = '{v, 12'b000000_00_00_11};
        lwv = z; lwv.MemtoRegE = 1; lwv.RtE = 5; lwv.RsD = 5;
        tbl[6] = '{lwv, C_HZ};
        v = lwv; v.RtE = 0; tbl[7] = '{v, C_NONE};
        brv = z; brv.BranchD = 1; brv.RegWriteE = 1; brv.WriteRegE = 3;
        brv.RtD = 3; brv.PCSrcD = 1;
        tbl[8] = '{brv, C_HZ};
        v = z; v.BranchD = 1; v.MemtoRegM = 1; v.WriteRegM = 7;
        v.RsD = 7; v.PCSrcD = 1;
        tbl[9] = '{v, C_HZ};
        v = z; v.PCSrcD = 1; tbl[10] = '{v, C_FD};
        v = brv; v.RegWriteE = 0; tbl[11] = '{v, C_FD};
        v = z; v.MemtoRegE = 1; v.RtE = 5; v.RtD = 5; v.PCSrcD = 1;
        tbl[12] = '{v, C_HZ};
        v = z; v.RegWriteW = 1; v.WriteRegW = 2; v.RtE = 2;
        tbl[13] = '{v, 12'b000000_00_01_00};

        // reset overrides everything, including live forwarding matches
        reset = 1'b1;
        apply(tbl[1].in);
        chk("rst_comb", gotComb(), C_RST);
        chk("rst_err", MemErr, 0);
        chk("rst_cnt", {StallCycles, FlushCount}, 0);
        advance();
        reset = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            chk($sformatf("tbl%0d", i), gotComb(), tbl[i].exp);
            advance();
        end

        // load-use: one stall cycle, then released
        doReset();
        apply(lwv);
        chk("lw_stall", gotComb(), C_HZ);
        advance();
        apply(z);
        chk("lw_release", gotComb(), C_NONE);
        chk("lw_cnt", {StallCycles, FlushCount}, {4'd1, 4'd1});
        advance();

        // branch waits for operands, then flushes D
        doReset();
        apply(brv);
        chk("br_stall", gotComb(), C_HZ);
        advance();
        v = z; v.PCSrcD = 1;
        apply(v);
        chk("br_flush", gotComb(), C_FD);
        chk("br_fc1", FlushCount, 1);
        advance();
        apply(z);
        chk("br_cnt", {StallCycles, FlushCount}, {4'd1, 4'd2});
        advance();

        // memory wait: 3 frozen cycles, freeze beats hazards and PCSrcD
        doReset();
        mem = z; mem.MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            v = mem;
            if (i == 1) begin
                v = lwv; v.MemReqM = 1; v.PCSrcD = 1;
            end
            apply(v);
            chk($sformatf("mw_frz%0d", i), gotComb(), C_FRZ);
            advance();
        end
        v = mem; v.MemReadyM = 1;
        apply(v);
        chk("mw_ready", gotComb(), C_NONE);
        advance();
        apply(z);
        chk("mw_run", gotComb(), C_NONE);
        chk("mw_sc", StallCycles, 3);
        advance();

        // timeout into sticky error, recovered only by reset
        doReset();
        for (int i = 0; i < TO; i++) begin
            apply(mem);
            chk($sformatf("to_frz%0d", i), {gotComb(), MemErr},
                {C_FRZ, 1'b0});
            advance();
        end
        v = z; v.MemReadyM = 1; v.PCSrcD = 1;
        apply(v);
        chk("to_err", {gotComb(), MemErr}, {C_FRZ, 1'b1});
        advance();
        reset = 1'b1;
        #1;
        chk("to_rst", {gotComb(), MemErr, StallCycles, FlushCount},
            {C_RST, 1'b0, 8'h00});
        advance();
        reset = 1'b0;
        apply(v);
        chk("to_resume", {gotComb(), MemErr}, {C_FD, 1'b0});
        advance();

        // counter saturation
        doReset();
        for (int i = 0; i < 20; i++) begin
            apply(lwv);
            if (i == 14) chk("sat_14", StallCycles, 14);
            advance();
        end
        apply(z);
        chk("sat_sc", StallCycles, SAT);
        chk("sat_fc", FlushCount, SAT);
        advance();

        // randomized traffic against the model
        doReset();
        mWait = 0; mErr = 0; mCnt = 0; mStall = 0; mFlush = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            r.RsD = 5'($urandom_range(0, 3));
            r.RtD = 5'($urandom_range(0, 3));
            r.RsE = 5'($urandom_range(0, 3));
            r.RtE = 5'($urandom_range(0, 3));
            r.WriteRegE = 5'($urandom_range(0, 3));
            r.WriteRegM = 5'($urandom_range(0, 3));
            r.WriteRegW = 5'($urandom_range(0, 3));
            r.RegWriteE = 1'($urandom_range(0, 1));
            r.RegWriteM = 1'($urandom_range(0, 1));
            r.RegWriteW = 1'($urandom_range(0, 1));
            r.MemtoRegE = 1'($urandom_range(0, 1));
            r.MemtoRegM = 1'($urandom_range(0, 1));
            r.BranchD = 1'($urandom_range(0, 1));
            r.PCSrcD = 1'($urandom_range(0, 1));
            r.MemReqM = ($urandom_range(0, 3) == 0);
            r.MemReadyM = ($urandom_range(0, 3) != 0);
            reset = rst;
            apply(r);
            e = model(r, rst, mWait, mErr);
            if (rst)
                chk("rand", {gotComb(), MemErr, StallCycles, FlushCount},
                    {e, 1'b0, 8'h00});
            else
                chk("rand", {gotComb(), MemErr, StallCycles, FlushCount},
                    {e, mErr, 4'(mStall), 4'(mFlush)});
            @(posedge clk);
            if (rst) begin
                mWait = 0; mErr = 0; mCnt = 0; mStall = 0; mFlush = 0;
            end else begin
                if (e[11] && mStall < SAT) mStall++;
                if ((e[7] || e[6]) && mFlush < SAT) mFlush++;
                if (!mErr) begin
                    if (e[9]) begin
                        mCnt++;
                        mWait = 1;
                        if (mCnt >= TO) mErr = 1;
                    end else begin
                        mWait = 0;
                        mCnt = 0;
                    end
                end
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
